// File: rtl/muldiv_param_if.sv
// Handshake and operand/result bundle for the shared muldiv_param unit.
interface muldiv_param_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               muordi;
    logic               sgn;
    logic [WIDTH-1:0]   opera1;
    logic [2*WIDTH-1:0] opera2;
    logic               ready;
    logic               valid;
    logic [2*WIDTH-1:0] result;
    logic               dz;
    logic               ovf;

    modport master (output start, muordi, sgn, opera1, opera2,
                    input  ready, valid, result, dz, ovf);
    modport slave  (input  start, muordi, sgn, opera1, opera2,
                    output ready, valid, result, dz, ovf);
endinterface

// File: rtl/muldiv_param.sv
// Shared sequential multiply/divide unit, one op in flight, one result bit per cycle.
// Works on magnitudes (shift-add mul LSB first, restoring div MSB first); signs are applied in FIX.
module muldiv_param #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_param_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0]  HALF = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;    // mul: {partial product, multiplier}; div: {remainder, dividend -> quotient}
    logic [W-1:0]   opb;    // multiplicand or divisor magnitude
    logic           is_div, sg, neg_q, neg_r, dz_r, ovf_r;

    // Operand magnitudes at accept; the most negative value maps to its unsigned magnitude.
    logic           a1_neg, m_neg, d_neg;
    logic [W-1:0]   a1_mag, m_mag;
    logic [2*W-1:0] d_mag;
    always_comb begin
        a1_neg = bus.sgn & bus.opera1[W-1];
        m_neg  = bus.sgn & bus.opera2[W-1];
        d_neg  = bus.sgn & bus.opera2[2*W-1];
        a1_mag = a1_neg ? -bus.opera1 : bus.opera1;
        m_mag  = m_neg  ? -bus.opera2[W-1:0] : bus.opera2[W-1:0];
        d_mag  = d_neg  ? -bus.opera2 : bus.opera2;
    end

    logic [W:0] add_sum, shl, sub;
    always_comb begin
        add_sum = {1'b0, acc[2*W-1:W]} + {1'b0, opb & {W{acc[0]}}};
        shl     = {acc[2*W-1:W], acc[W-1]};
        sub     = shl - {1'b0, opb};
    end

    logic [W-1:0] q_mag, r_mag, q_fix, r_fix;
    logic         fix_ovf;
    always_comb begin
        q_mag   = acc[W-1:0];
        r_mag   = acc[2*W-1:W];
        q_fix   = neg_q ? -q_mag : q_mag;
        r_fix   = neg_r ? -r_mag : r_mag;
        // unsigned quotients always fit once the early check has passed
        fix_ovf = sg & (neg_q ? (q_mag > HALF) : q_mag[W-1]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            opb        <= '0;
            is_div     <= 1'b0;
            sg         <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
            bus.ready  <= 1'b1;
            bus.valid  <= 1'b0;
            bus.result <= '0;
            bus.dz     <= 1'b0;
            bus.ovf    <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    is_div    <= bus.muordi;
                    sg        <= bus.sgn;
                    cnt       <= '0;
                    dz_r      <= 1'b0;
                    ovf_r     <= 1'b0;
                    bus.ready <= 1'b0;
                    if (!bus.muordi) begin
                        opb   <= m_mag;
                        acc   <= {{W{1'b0}}, a1_mag};
                        neg_q <= a1_neg ^ m_neg;
                        neg_r <= 1'b0;
                        state <= ITER;
                    end else begin
                        opb   <= a1_mag;
                        neg_q <= a1_neg ^ d_neg;
                        neg_r <= d_neg;
                        if (a1_mag == '0) begin
                            dz_r  <= 1'b1;
                            acc   <= {bus.opera2[W-1:0], {W{1'b1}}};
                            state <= DONE;
                        end else if (d_mag[2*W-1:W] >= a1_mag) begin
                            ovf_r <= 1'b1;
                            acc   <= '0;
                            state <= DONE;
                        end else begin
                            acc   <= d_mag;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (is_div)
                        acc <= sub[W] ? {shl[W-1:0], acc[W-2:0], 1'b0}
                                      : {sub[W-1:0], acc[W-2:0], 1'b1};
                    else
                        acc <= {add_sum, acc[W-1:1]};
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        acc <= neg_q ? -acc : acc;
                    end else if (fix_ovf) begin
                        acc   <= '0;
                        ovf_r <= 1'b1;
                    end else begin
                        acc <= {r_fix, q_fix};
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.result <= acc;
                    bus.dz     <= dz_r;
                    bus.ovf    <= ovf_r;
                    bus.valid  <= 1'b1;
                    bus.ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_param.sv
// Self-checking bench for muldiv_param: directed vectors, randomized ops against a wide-arithmetic model,
// start spamming during an op, and asynchronous reset mid-iteration.
module tb_muldiv_param;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_param_if #(.WIDTH(W)) bus ();
    muldiv_param #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    localparam logic signed [127:0] LIM_HI = 128'sh7FFF_FFFF;
    localparam logic signed [127:0] LIM_LO = -128'sh8000_0000;
    localparam logic signed [127:0] U_MAX  = 128'shFFFF_FFFF;
    localparam logic signed [127:0] TWO_W  = 128'sh1_0000_0000;

    // Reference: exact integer arithmetic on 128-bit signed values.
    function automatic void model(input bit div, input bit s, input logic [W-1:0] a1,
                                  input logic [2*W-1:0] a2, output logic [2*W-1:0] res,
                                  output logic edz, output logic eovf, output int lat);
        logic signed [127:0] n, d, q, r, aq;
        res = '0; edz = 1'b0; eovf = 1'b0; lat = W + 2;
        d = {{96{s & a1[W-1]}}, a1};
        if (!div) begin
            n = {{96{s & a2[W-1]}}, a2[W-1:0]};
            q = n * d;
            res = q[2*W-1:0];
        end else if (a1 == '0) begin
            edz = 1'b1;
            res = {a2[W-1:0], {W{1'b1}}};
            lat = 1;
        end else begin
            n  = {{64{s & a2[2*W-1]}}, a2};
            q  = n / d;
            r  = n % d;
            aq = (q < 0) ? -q : q;
            if (aq >= TWO_W) lat = 1;
            eovf = s ? ((q > LIM_HI) || (q < LIM_LO)) : (q > U_MAX);
            res  = eovf ? '0 : {r[W-1:0], q[W-1:0]};
        end
    endfunction

    // Drive one op, scramble inputs after accept, wait (bounded) for valid, then sample one more cycle.
    task automatic run_op(input bit div, input bit s, input logic [W-1:0] a1, input logic [2*W-1:0] a2,
                          output logic [2*W-1:0] res, output logic odz, output logic oovf, output int lat,
                          output int rdy_low, output logic v2, output logic [2*W-1:0] res2);
        @(negedge clock);
        bus.start = 1'b1; bus.muordi = div; bus.sgn = s; bus.opera1 = a1; bus.opera2 = a2;
        @(posedge clock);
        lat = -1; rdy_low = 0; res = '0; odz = 1'b0; oovf = 1'b0; v2 = 1'b0; res2 = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            bus.start  = 1'b0;
            bus.muordi = 1'($urandom);
            bus.sgn    = 1'($urandom);
            bus.opera1 = $urandom;
            bus.opera2 = {$urandom, $urandom};
            if (!bus.ready) rdy_low++;
            if (bus.valid) begin
                lat = n; res = bus.result; odz = bus.dz; oovf = bus.ovf;
                @(negedge clock);
                v2 = bus.valid; res2 = bus.result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.muordi = 1'b0; bus.sgn = 1'b0; bus.opera1 = '0; bus.opera2 = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        checks++; if (bus.result !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++; if (bus.dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", bus.dz); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
        reset = 1'b1;
    endtask

    typedef struct {
        bit          div;
        bit          s;
        logic [31:0] a1;
        logic [63:0] a2;
        logic [63:0] res;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[10];
        logic [63:0] res, res2;
        logic odz, oovf, v2;
        int lat, rlow;
        vecs[0] = '{0, 1, 32'hFFFF_FFF9, 64'h6,                   64'hFFFF_FFFF_FFFF_FFD6, 0, 0, 34};
        vecs[1] = '{0, 0, 32'hFFFF_FFFF, 64'hFFFF_FFFF,           64'hFFFF_FFFE_0000_0001, 0, 0, 34};
        vecs[2] = '{0, 0, 32'h5,         64'hDEAD_BEEF_0000_0003, 64'hF,                   0, 0, 34};
        vecs[3] = '{1, 1, 32'hFFFF_FFF9, 64'd100,                 64'h0000_0002_FFFF_FFF2, 0, 0, 34};
        vecs[4] = '{1, 1, 32'h7,         64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFE_FFFF_FFF2, 0, 0, 34};
        vecs[5] = '{1, 0, 32'h7,         64'd100,                 64'h0000_0002_0000_000E, 0, 0, 34};
        vecs[6] = '{1, 0, 32'h0,         64'h55,                  64'h0000_0055_FFFF_FFFF, 1, 0, 1};
        vecs[7] = '{1, 0, 32'h1,         64'h1_0000_0000,         64'h0,                   0, 1, 1};
        vecs[8] = '{1, 1, 32'h1,         64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 0, 0, 34};
        vecs[9] = '{1, 1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h0,                   0, 1, 34};
        foreach (vecs[i]) begin
            run_op(vecs[i].div, vecs[i].s, vecs[i].a1, vecs[i].a2, res, odz, oovf, lat, rlow, v2, res2);
            checks++; if (res !== vecs[i].res) begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, res, vecs[i].res); end
            checks++; if (odz !== vecs[i].dz) begin errors++; $display("FAIL dir%0d_dz got %b exp %b", i, odz, vecs[i].dz); end
            checks++; if (oovf !== vecs[i].ovf) begin errors++; $display("FAIL dir%0d_ovf got %b exp %b", i, oovf, vecs[i].ovf); end
            checks++; if (lat !== vecs[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, vecs[i].lat); end
            checks++; if (rlow !== vecs[i].lat) begin errors++; $display("FAIL dir%0d_ready_low got %0d exp %0d", i, rlow, vecs[i].lat); end
            checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL dir%0d_valid_pulse got %b exp 0", i, v2); end
            checks++; if (res2 !== vecs[i].res) begin errors++; $display("FAIL dir%0d_hold got %h exp %h", i, res2, vecs[i].res); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a1;
        logic [63:0] a2, res, res2, eres;
        logic odz, oovf, v2, edz, eovf;
        bit div, s;
        int lat, elat, rlow;
        for (int i = 0; i < 80; i++) begin
            div = 1'($urandom); s = 1'($urandom);
            a1 = $urandom; a2 = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: a1 = '0;
                1: a2[63:32] = s ? {32{a2[31]}} : 32'h0;
                2: a1 = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                3: a2[63:32] = $urandom % (a1 | 32'h1);
                default: ;
            endcase
            model(div, s, a1, a2, eres, edz, eovf, elat);
            run_op(div, s, a1, a2, res, odz, oovf, lat, rlow, v2, res2);
            checks++; if (res !== eres) begin errors++; $display("FAIL rnd%0d_result div=%b s=%b a1=%h a2=%h got %h exp %h", i, div, s, a1, a2, res, eres); end
            checks++; if (odz !== edz) begin errors++; $display("FAIL rnd%0d_dz got %b exp %b", i, odz, edz); end
            checks++; if (oovf !== eovf) begin errors++; $display("FAIL rnd%0d_ovf got %b exp %b", i, oovf, eovf); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, elat); end
            checks++; if (res2 !== eres) begin errors++; $display("FAIL rnd%0d_hold got %h exp %h", i, res2, eres); end
        end
    endtask

    // start held high through a whole op: one valid only, second op accepted once ready returns.
    task automatic test_back_to_back();
        logic [31:0] a1, b1;
        logic [63:0] a2, b2, ea, eb, res_a, res_b;
        logic edz, eovf;
        int elat, vcount, rlow, lat_a, lat_b;
        a1 = $urandom; a2 = {$urandom, $urandom};
        b1 = $urandom; b2 = {$urandom, $urandom};
        model(1'b0, 1'b1, a1, a2, ea, edz, eovf, elat);
        model(1'b0, 1'b0, b1, b2, eb, edz, eovf, elat);
        @(negedge clock);
        bus.start = 1'b1; bus.muordi = 1'b0; bus.sgn = 1'b1; bus.opera1 = a1; bus.opera2 = a2;
        @(posedge clock);
        vcount = 0; rlow = 0; lat_a = -1; res_a = '0;
        for (int n = 0; n <= 34; n++) begin
            @(negedge clock);
            bus.sgn = 1'b0; bus.opera1 = b1; bus.opera2 = b2;
            if (!bus.ready) rlow++;
            if (bus.valid) begin vcount++; lat_a = n; res_a = bus.result; end
        end
        @(negedge clock);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept ready got %b exp 0", bus.ready); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_no_double_valid got %b exp 0", bus.valid); end
        bus.start = 1'b0;
        checks++; if (vcount !== 1) begin errors++; $display("FAIL b2b_valid_count got %0d exp 1", vcount); end
        checks++; if (rlow !== 34) begin errors++; $display("FAIL b2b_ready_low got %0d exp 34", rlow); end
        checks++; if (lat_a !== 34) begin errors++; $display("FAIL b2b_first_latency got %0d exp 34", lat_a); end
        checks++; if (res_a !== ea) begin errors++; $display("FAIL b2b_first_result got %h exp %h", res_a, ea); end
        lat_b = -1; res_b = '0;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) @(negedge clock);
            if (bus.valid) begin lat_b = n; res_b = bus.result; break; end
        end
        checks++; if (lat_b !== 34) begin errors++; $display("FAIL b2b_second_latency got %0d exp 34", lat_b); end
        checks++; if (res_b !== eb) begin errors++; $display("FAIL b2b_second_result got %h exp %h", res_b, eb); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a1;
        logic [63:0] a2, res, res2, eres;
        logic odz, oovf, v2, edz, eovf;
        int lat, elat, rlow, vcount;
        @(negedge clock);
        bus.start = 1'b1; bus.muordi = 1'b0; bus.sgn = 1'b0; bus.opera1 = 32'hFFFF_FFFF; bus.opera2 = 64'h1234_5678;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.ready); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.valid); end
        checks++; if (bus.result !== 64'h0) begin errors++; $display("FAIL rstmid_result got %h exp 0", bus.result); end
        @(negedge clock);
        reset = 1'b1;
        vcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (bus.valid) vcount++;
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", vcount); end
        a1 = 32'd13; a2 = {32'h0000_0005, $urandom};
        model(1'b1, 1'b0, a1, a2, eres, edz, eovf, elat);
        run_op(1'b1, 1'b0, a1, a2, res, odz, oovf, lat, rlow, v2, res2);
        checks++; if (res !== eres) begin errors++; $display("FAIL rstmid_after_result got %h exp %h", res, eres); end
        checks++; if (lat !== elat) begin errors++; $display("FAIL rstmid_after_latency got %0d exp %0d", lat, elat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
